// File: rtl/spike_rate_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : spike_rate_encoder
//  Function : Loads one pixel frame over AXI-Stream, emits per-line rate-coded
//             spike trains for ENCODE_TIME cycles, then REST_TIME zero cycles.
//             Build option SPIKE_ENC_DETERMINISTIC_EN selects phase-accumulator
//             encoding instead of the default LFSR stochastic encoding.
//  Revision : 1.0 - initial release
// ============================================================================
module spike_rate_encoder #(
    parameter int          N_INPUTS    = 2,
    parameter int          PIX_W       = 8,
    parameter int          ENCODE_TIME = 350,
    parameter int          REST_TIME   = 150,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PIX_W-1:0]    s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [N_INPUTS-1:0] pre_spikes,
    output logic                sample_start,
    output logic                sample_done,
    output logic                busy,
    output logic                frame_err
);

    localparam int c_cnt_max = (ENCODE_TIME > REST_TIME) ? ENCODE_TIME : REST_TIME;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [c_cnt_w-1:0] c_enc_last  = c_cnt_w'(ENCODE_TIME - 1);
    localparam logic [c_cnt_w-1:0] c_rest_last = c_cnt_w'(REST_TIME - 1);
    localparam logic [c_idx_w-1:0] c_last_beat = c_idx_w'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ENCODE = 2'd1,
        S_REST   = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_beat_idx;
    logic [PIX_W-1:0]      r_intensity [N_INPUTS];
    logic [N_INPUTS-1:0]   r_pre;
    logic                  r_start;
    logic                  r_frame_err;
    logic [N_INPUTS-1:0]   w_spike;
    logic                  w_last_beat;

`ifdef SPIKE_ENC_DETERMINISTIC_EN
    // Only the fractional phase is stored; the carry is recomputed each cycle.
    logic [PIX_W-1:0]      r_acc      [N_INPUTS];
    logic [PIX_W:0]        w_acc_next [N_INPUTS];
`else
    logic [15:0]           r_lfsr     [N_INPUTS];

    function automatic logic [15:0] f_seed(input int idx);
        logic [15:0] s;
        s = LFSR_SEED ^ 16'(16'h9E37 * (idx + 1));
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] f_lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
`ifdef SPIKE_ENC_DETERMINISTIC_EN
            w_acc_next[i] = {1'b0, r_acc[i]} + {1'b0, r_intensity[i]};
            w_spike[i]    = w_acc_next[i][PIX_W];
`else
            w_spike[i]    = (r_lfsr[i][PIX_W-1:0] < r_intensity[i]);
`endif
        end
    end

    assign w_last_beat = (r_beat_idx == c_last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_beat_idx  <= '0;
            r_pre       <= '0;
            r_start     <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                r_intensity[i] <= '0;
`ifdef SPIKE_ENC_DETERMINISTIC_EN
                r_acc[i]       <= '0;
`else
                r_lfsr[i]      <= f_seed(i);
`endif
            end
        end else if (en) begin
            r_start <= (r_state == S_ENCODE) && (r_cnt == '0);
            unique case (r_state)
                S_LOAD: begin
                    r_pre <= '0;
                    if (s_axis_tvalid) begin
                        r_intensity[r_beat_idx] <= s_axis_tdata;
                        if (w_last_beat != s_axis_tlast)
                            r_frame_err <= 1'b1;
                        if (w_last_beat || s_axis_tlast) begin
                            // Short frame: lines beyond the tlast beat stay silent.
                            for (int i = 0; i < N_INPUTS; i++) begin
                                if (c_idx_w'(i) > r_beat_idx)
                                    r_intensity[i] <= '0;
`ifdef SPIKE_ENC_DETERMINISTIC_EN
                                r_acc[i] <= '0;
`endif
                            end
                            r_beat_idx <= '0;
                            r_cnt      <= '0;
                            r_state    <= S_ENCODE;
                        end else begin
                            r_beat_idx <= r_beat_idx + 1'b1;
                        end
                    end
                end
                S_ENCODE: begin
                    r_pre <= w_spike;
                    for (int i = 0; i < N_INPUTS; i++) begin
`ifdef SPIKE_ENC_DETERMINISTIC_EN
                        r_acc[i]  <= w_acc_next[i][PIX_W-1:0];
`else
                        r_lfsr[i] <= f_lfsr_next(r_lfsr[i]);
`endif
                    end
                    if (r_cnt == c_enc_last) begin
                        r_cnt   <= '0;
                        r_state <= S_REST;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REST: begin
                    r_pre <= '0;
                    if (r_cnt == c_rest_last) begin
                        r_cnt      <= '0;
                        r_beat_idx <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Held registers are masked while frozen so a due pulse appears on resume.
    assign pre_spikes    = r_pre & {N_INPUTS{en}};
    assign sample_start  = r_start & en;
    assign sample_done   = en && (r_state == S_REST) && (r_cnt == c_rest_last);
    assign s_axis_tready = en && (r_state == S_LOAD);
    assign busy          = (r_state != S_LOAD);
    assign frame_err     = r_frame_err;

endmodule
`default_nettype wire

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Upstream input stage for the spiking network: accepts one pixel-intensity frame over AXI-Stream, then drives per-input pre-synaptic spike trains (`pre_spikes[i]`, one bit per synapse `pre_spiking` port) for `ENCODE_TIME` cycles. It then holds all spikes at zero for `REST_TIME` cycles so neuron membranes and traces decay between samples, and returns to accepting the next frame. All spikes are in the single `clk` domain.

## Interface
- `N_INPUTS`, 2: number of pre-synaptic lines (one per synapse).
- `PIX_W`, 8: intensity width, unsigned.
- `ENCODE_TIME`, 350: spiking window length in cycles (≥1).
- `REST_TIME`, 150: zero-insertion window in cycles (≥1).
- `LFSR_SEED`, 16'hACE1: base seed. Line i seeds with `LFSR_SEED ^ (16'h9E37*(i+1))`; a zero result is replaced by 16'h0001.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable; low freezes all state.
- `s_axis_tdata` in PIX_W: pixel intensity, unsigned.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tlast` in 1: last pixel of frame.
- `s_axis_tready` out 1: beat accepted when tvalid&tready&en.
- `pre_spikes` out N_INPUTS: registered spike vector.
- `sample_start` out 1: one-cycle pulse, first ENCODE cycle.
- `sample_done` out 1: one-cycle pulse, last REST cycle.
- `busy` out 1: high in ENCODE and REST.
- `frame_err` out 1: sticky, tlast position mismatch.

## Operation
- FSM: LOAD → ENCODE → REST → LOAD. Reset state is LOAD.
- LOAD: `s_axis_tready`=1 (while `en`). Each accepted beat writes `intensity[beat_idx]`, beat_idx++.
  - Beat N_INPUTS-1 accepted → ENCODE.
  - tlast on an earlier beat: the remaining intensities are cleared to 0, `frame_err` is set, → ENCODE.
  - tlast absent on beat N_INPUTS-1: `frame_err` is set, and the extra beats are consumed in the next LOAD as a new frame.
- ENCODE: each cycle, line i: `pre_spikes[i] <= (lfsr_i[PIX_W-1:0] < intensity[i])`. Spike probability = intensity/2^PIX_W; 0 never spikes. Each LFSR (16-bit Galois, taps 0xB400) advances every ENCODE cycle. The cycle counter runs 0..ENCODE_TIME-1, then → REST.
- REST: `pre_spikes`=0. The counter runs 0..REST_TIME-1, then → LOAD with beat_idx=0.
- `en`=0: FSM, counters, LFSRs and beat_idx hold. `pre_spikes` is driven 0. `s_axis_tready`=0. Pulses are suppressed; a pulse due in a frozen cycle fires on the first enabled cycle instead.
- LFSRs are not reseeded per frame; they are seeded only at reset.
- `frame_err` clears only on `rst`.

## Timing
- Reset values: `pre_spikes`=0, `s_axis_tready`=1, `sample_start`=0, `sample_done`=0, `busy`=0, `frame_err`=0. Intensities, counters and beat_idx are 0; LFSRs hold their seeds.
- Last-beat acceptance at edge k → the FSM is in ENCODE from cycle k+1. The first spike-valid `pre_spikes` value appears after edge k+1, and `sample_start` is high in the same cycle. Latency from the last beat to the first spike is 1 cycle.
- `pre_spikes` is high for at most ENCODE_TIME enabled cycles per frame, followed by exactly REST_TIME zero cycles.
- `sample_done` is high in the last REST cycle. `s_axis_tready` rises on the next cycle.
- Frame period with continuous tvalid and `en`=1 is N_INPUTS + ENCODE_TIME + REST_TIME cycles.
- `rst` asserted mid-frame: all outputs go to reset values immediately (asynchronous). The partially loaded frame is discarded.

## Configuration
- `SPIKE_ENC_DETERMINISTIC_EN` defined: the LFSR compare is replaced by a per-line (PIX_W+1)-bit phase accumulator.
  - `acc_i <= acc_i[PIX_W-1:0] + intensity[i]`; `pre_spikes[i]` = carry bit.
  - Accumulators clear on entry to ENCODE.
  - Yields exactly floor(intensity·ENCODE_TIME/2^PIX_W) spikes per window.
- Undefined: the LFSR stochastic encoding described above. The port list is identical in both builds.

## Test plan
- Reset, then frame {0, 255} with tlast on beat 2 → `sample_start` 1 cycle after the last beat. Line 0 gives 0 spikes in 350 cycles. Line 1 gives 349±1 spikes (LFSR build); a byte value of 255 never fires.
- Deterministic build, frame {128, 64} → line 0 spikes every 2nd cycle (175 spikes); line 1 every 4th (87 spikes). Then 150 zero cycles, then `sample_done`.
- Early tlast on beat 1 → intensity[1]=0, `frame_err`=1, ENCODE starts 1 cycle later, line 1 silent.
- `en` low for 20 cycles mid-ENCODE → `pre_spikes`=0 during the gap. Total ENCODE enabled cycles remain 350; the spike sequence resumes unchanged (deterministic build).
- `rst` pulse mid-REST → all outputs reset asynchronously within the cycle. The next frame is accepted immediately and the LFSR sequence restarts from the seed.
- Two back-to-back frames with continuous tvalid → tready low for exactly 500 cycles between frames; the period is 502 cycles.
